// File: rtl/bytebeat_sequencer.sv
// Sample-rate sequencer for a bytebeat generator core: ticks a divider, hands the core a
// parameter set, collects the returned PCM sample. Optional BYTEBEAT_SEQ_MUTE_EN adds `mute`.
module bytebeat_sequencer #(
    parameter int unsigned DIV_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic [15:0]      param_in,
    input  logic             param_ld,
    output logic [3:0]       a_out,
    output logic [3:0]       b_out,
    output logic [3:0]       c_out,
    output logic [3:0]       d_out,
    output logic             a_vld,
    output logic             b_vld,
    output logic             c_vld,
    output logic             d_vld,
    input  logic             a_rdy,
    input  logic             b_rdy,
    input  logic             c_rdy,
    input  logic             d_rdy,
    input  logic [7:0]       pcm_in,
    input  logic             pcm_in_vld,
    output logic             pcm_in_rdy,
`ifdef BYTEBEAT_SEQ_MUTE_EN
    input  logic             mute,
`endif
    output logic [7:0]       pcm_out,
    output logic             sample_strobe,
    output logic             overrun,
    input  logic             overrun_clr
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      act_q, act_d;
    logic [3:0]       done_q, done_d;
    logic [7:0]       pcm_q, pcm_d;
    logic             strobe_q, strobe_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic [3:0]       chan_vld, chan_rdy;

    assign tick     = (cnt_q == '0);
    assign cnt_d    = tick ? div : cnt_q - DIV_W'(1);
    assign shadow_d = param_ld ? param_in : shadow_q;

    // Channel bit 0 is a, bit 3 is d.
    assign chan_rdy = {d_rdy, c_rdy, b_rdy, a_rdy};
    assign chan_vld = (state_q == StIssue) ? ~done_q : 4'b0000;

    // Ticks that arrive while a transaction is in flight are dropped, not queued.
    assign overrun_d = (tick && (state_q != StIdle)) || (overrun_q && !overrun_clr);

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        done_d     = done_q;
        pcm_d      = pcm_q;
        strobe_d   = 1'b0;
        pcm_in_rdy = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick) begin
                    act_d   = shadow_q;
                    done_d  = 4'b0000;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                done_d = done_q | (chan_vld & chan_rdy);
                if (&done_d) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                pcm_in_rdy = 1'b1;
                if (pcm_in_vld) begin
                    pcm_d    = pcm_in;
                    strobe_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shadow_q  <= '0;
            act_q     <= '0;
            done_q    <= '0;
            pcm_q     <= 8'h00;
            strobe_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            act_q     <= act_d;
            done_q    <= done_d;
            pcm_q     <= pcm_d;
            strobe_q  <= strobe_d;
            overrun_q <= overrun_d;
        end
    end

    assign a_out         = act_q[3:0];
    assign b_out         = act_q[7:4];
    assign c_out         = act_q[11:8];
    assign d_out         = act_q[15:12];
    assign a_vld         = chan_vld[0];
    assign b_vld         = chan_vld[1];
    assign c_vld         = chan_vld[2];
    assign d_vld         = chan_vld[3];
    assign sample_strobe = strobe_q;
    assign overrun       = overrun_q;

`ifdef BYTEBEAT_SEQ_MUTE_EN
    // Muting only masks the pins; the accepted sample is still tracked underneath.
    assign pcm_out = mute ? 8'h80 : pcm_q;
`else
    assign pcm_out = pcm_q;
`endif

endmodule
